// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to TRIGGER_ADDR, halt the CPU and copy page $XX00-$XXFF
// into PPU OAM through 256 OAMDATA writes. Reads happen on get cycles and writes on put cycles.
//
// state | meaning
// IDLE  | waiting for a CPU write to TRIGGER_ADDR
// HALT  | CPU halted, bus owned, no strobes
// ALIGN | one idle cycle so that the first READ lands on a get cycle
// READ  | read {page, idx} into the byte buffer
// WRITE | write the buffered byte to OAMDATA, then advance idx or finish
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_REG  = 3'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_w,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic        mem_r,
  input  logic [7:0]  mem_rdata,
  output logic [2:0]  ppu_addr,
  output logic        ppu_w,
  output logic [7:0]  ppu_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      buf_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = ~parity_q;
    page_d   = page_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_w && (cpu_addr == TRIGGER_ADDR)) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      // parity_q==1 here means the following cycle is a get cycle
      S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        buf_d   = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on the cpu_* inputs
  always_comb begin
    dma_active = (state_q != S_IDLE);
    mem_r      = 1'b0;
    mem_addr   = 16'h0000;
    ppu_w      = 1'b0;
    ppu_addr   = 3'd0;
    ppu_wdata  = 8'h00;
    if (state_q == S_READ) begin
      mem_r    = 1'b1;
      mem_addr = {page_q, idx_q};
    end
    if (state_q == S_WRITE) begin
      ppu_w     = 1'b1;
      ppu_addr  = OAMDATA_REG;
      ppu_wdata = buf_q;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: reset, idle decoding, full transfers on both parities,
// page $FF wrap, ignored re-trigger, mid-transfer reset and back-to-back trigger.
module tb_oam_dma;

  localparam logic [15:0] TRIG = 16'h4014;

  logic        CLK;
  logic        RESET;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_w;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_r;
  logic [7:0]  mem_rdata;
  logic [2:0]  ppu_addr;
  logic        ppu_w;
  logic [7:0]  ppu_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  oam_dma dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_w      (cpu_w),
    .dma_active (dma_active),
    .mem_addr   (mem_addr),
    .mem_r      (mem_r),
    .mem_rdata  (mem_rdata),
    .ppu_addr   (ppu_addr),
    .ppu_w      (ppu_w),
    .ppu_wdata  (ppu_wdata)
  );

  // Memory model: byte at address a is a[7:0]^$A5
  assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Mirror of the get/put parity: cyc[0] equals the DUT parity between edges
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Triggers in the first cycle whose parity is t_par.
  task automatic run_xfer(input logic [7:0] pg, input logic t_par, input int exp_len,
                          input int exp_nw, input int retrig_at, input int reset_at);
    int act, nw, nr, first_par, addr_err, data_err, quiet_err, par_err;
    act = 0; nw = 0; nr = 0; first_par = 1;
    addr_err = 0; data_err = 0; quiet_err = 0; par_err = 0;
    for (int w = 0; w < 4 && cyc[0] != t_par; w++) @(negedge CLK);
    check("idle_at_trigger", dma_active, 1'b0);
    cpu_addr = TRIG; cpu_wdata = pg; cpu_w = 1'b1;
    @(negedge CLK);
    cpu_w = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    check("halt_active", dma_active, 1'b1);
    check("halt_quiet", {mem_r, mem_addr, ppu_w, ppu_addr, ppu_wdata}, 32'h0);
    for (int c = 0; c < 600 && dma_active; c++) begin
      act++;
      if (mem_r) begin
        if (nr == 0) first_par = cyc[0];
        if (cyc[0] != 0) par_err++;
        if (mem_addr !== {pg, nr[7:0]}) addr_err++;
        nr++;
      end else if (mem_addr !== 16'h0000) quiet_err++;
      if (ppu_w) begin
        if (cyc[0] != 1) par_err++;
        if (ppu_wdata !== (nw[7:0] ^ 8'hA5) || ppu_addr !== 3'd4) data_err++;
        nw++;
        if (nw == retrig_at) begin
          cpu_addr = TRIG; cpu_wdata = 8'h77; cpu_w = 1'b1;
        end
        if (nw == reset_at) RESET = 1'b1;
      end else if ({ppu_addr, ppu_wdata} !== 11'h0) quiet_err++;
      if (mem_r && ppu_w) quiet_err++;
      @(negedge CLK);
      cpu_w = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    end
    check("active_len", act, exp_len);
    check("write_count", nw, exp_nw);
    check("read_count", nr, exp_nw);
    check("read_addr_errs", addr_err, 0);
    check("write_data_errs", data_err, 0);
    check("idle_strobe_errs", quiet_err, 0);
    check("parity_errs", par_err, 0);
    check("first_read_parity", first_par, 0);
    if (RESET) begin
      check("reset_outputs", {dma_active, mem_r, mem_addr, ppu_w, ppu_addr, ppu_wdata}, 32'h0);
      RESET = 1'b0;
      @(negedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_w = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_active", dma_active, 1'b0);
    check("rst_mem", {mem_r, mem_addr}, 32'h0);
    check("rst_ppu", {ppu_w, ppu_addr, ppu_wdata}, 32'h0);

    // Writes to neighbouring registers must not start a transfer
    cpu_addr = 16'h4013; cpu_wdata = 8'h02; cpu_w = 1'b1;
    @(negedge CLK);
    cpu_addr = 16'h2004;
    @(negedge CLK);
    cpu_w = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("idle_quiet", {dma_active, mem_r, mem_addr, ppu_w, ppu_addr, ppu_wdata}, 32'h0);
      @(negedge CLK);
    end

    run_xfer(8'h02, 1'b0, 513, 256, -1, -1);
    // back-to-back: trigger in the first IDLE cycle after the final write
    run_xfer(8'hFF, 1'b0, 513, 256, -1, -1);
    run_xfer(8'h02, 1'b1, 514, 256, -1, -1);
    run_xfer(8'h35, 1'b1, 514, 256, 100, -1);
    run_xfer(8'h10, 1'b0, 75, 37, -1, 37);
    run_xfer(8'h11, 1'b0, 513, 256, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA initiator on the CPU side of the PPU register bus. A CPU write to $4014 halts the CPU, copies 256 bytes from CPU page $XX00–$XXFF into PPU OAM through repeated writes to register 4 (OAMDATA), then releases the CPU. It sits between the CPU bus decode and `ppu_top`'s `addr`/`w`/`reg_data_in` inputs, muxed over the CPU's own drive while `dma_active` is high.

## Interface
Parameters:
- `TRIGGER_ADDR`, 16'h4014, CPU address that starts a transfer
- `OAMDATA_REG`, 3'd4, PPU register index written per byte

Ports:
- `CLK`  in  1  system clock, one CPU cycle per edge
- `RESET`  in  1  synchronous, active-high
- `cpu_addr`  in  16  CPU bus address
- `cpu_wdata`  in  8  CPU write data
- `cpu_w`  in  1  CPU write strobe
- `dma_active`  out  1  high while the transfer owns the bus; CPU halts and the bus mux selects DMA
- `mem_addr`  out  16  read address {page, idx}
- `mem_r`  out  1  read strobe
- `mem_rdata`  in  8  read data, combinationally valid in the same cycle as `mem_r`
- `ppu_addr`  out  3  PPU register index
- `ppu_w`  out  1  PPU register write strobe
- `ppu_wdata`  out  8  byte to OAMDATA

## Operation
- Internal `parity` bit toggles every cycle; reset to 0. Parity 0 = get cycle, parity 1 = put cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: if `cpu_w && cpu_addr==TRIGGER_ADDR`, latch `page<=cpu_wdata`, `idx<=0`, go to HALT.
- HALT (1 cycle): `dma_active`=1, no strobes. Next state is READ if the next cycle is a get cycle (current parity==1), else ALIGN.
- ALIGN (1 cycle): `dma_active`=1, no strobes. Next state is READ.
- READ: `mem_r`=1, `mem_addr={page,idx}`. Latch `buf<=mem_rdata`. Next state is WRITE.
- WRITE: `ppu_w`=1, `ppu_addr=OAMDATA_REG`, `ppu_wdata=buf`. If `idx==255`, go to IDLE; else `idx<=idx+1` (8-bit) and go to READ.
- `ppu_addr`/`ppu_wdata` are 0 whenever `ppu_w`=0. `mem_addr` is 0 whenever `mem_r`=0.
- Triggers are ignored outside IDLE.
- `page` is unaffected by `idx` wrap; no carry into the page.

## Timing
- Reset values: `dma_active`=0, `mem_r`=0, `mem_addr`=0, `ppu_w`=0, `ppu_addr`=0, `ppu_wdata`=0. `parity`, `idx`, `page` and `buf` are 0; state is IDLE.
- All outputs are decoded from registered state. No combinational path from `cpu_*` to outputs.
- Trigger is sampled in cycle T. `dma_active` rises in T+1 (HALT).
- Transfer length is 513 cycles (HALT + 256 READ/WRITE pairs) when T+2 is a get cycle, otherwise 514 cycles (ALIGN inserted).
- Each byte takes exactly 2 cycles: READ on parity 0, WRITE on parity 1.
- `dma_active` falls in the cycle after the final WRITE.
- A trigger in that same cycle (back in IDLE) is honoured.
- RESET asserted in any state returns to IDLE next edge, with all outputs at reset values. A partial OAM copy is not resumed.

## Test plan
- Reset, then trigger $4014←$02 on a cycle whose successor parity is 1 (T+2 parity 0) -> `dma_active` high exactly 513 cycles; 256 `ppu_w` pulses; nth write carries memory[$0200+n].
- Same trigger shifted by one cycle -> one ALIGN cycle; `dma_active` high 514 cycles; first `mem_r` on a parity-0 cycle.
- Memory model returns `addr[7:0]^8'hA5`, page $FF -> writes $A5,$A4,…,$5A in order. `mem_addr` spans $FF00–$FFFF with no carry to $0000.
- CPU writes $4014 again at write #100 -> ignored; byte count stays 256; page unchanged.
- RESET asserted at write #37 -> next cycle all outputs 0 and `dma_active`=0. A new trigger then restarts from idx 0.
- Writes to $4013/$2004 by CPU while IDLE -> no DMA start; all outputs remain 0.
